// File: rtl/chameleon_fb_pkg.sv
// Shared types and constants for the Chameleon frame-buffer read side.
// Optional build macro: CHAMELEON_FB_PATTERN_EN (test-pattern source, see top).
package chameleon_fb_pkg;

  localparam int H_ACTIVE   = 256;
  localparam int V_ACTIVE   = 256;
  localparam int LAYER_SIZE = 65536;
  localparam int ADDR_W     = 17;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    SHOW = 1'b0,
    PEND = 1'b1
  } swap_state_e;

  // What the output stage does with a pixel slot once it reaches the end of the pipe.
  typedef enum logic [1:0] {
    PK_BLANK = 2'd0,
    PK_OOR   = 2'd1,
    PK_READ  = 2'd2
  } pix_kind_e;

  // Bit-replicating expansion so full-scale codes map to full-scale 8-bit values.
  function automatic rgb888_t rgb332_to_888(input rgb332_t q);
    rgb888_t o;
    o.r = {q[7:5], q[7:5], q[7:6]};
    o.g = {q[4:2], q[4:2], q[4:3]};
    o.b = {q[1:0], q[1:0], q[1:0], q[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/chameleon_fb_swap.sv
// Layer swap control: rising-edge detect on frame_done/vblank, SHOW/PEND FSM,
// scan-out layer select and saturating count of frames dropped before display.
module chameleon_fb_swap
  import chameleon_fb_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        frame_done,
  input  logic        vblank,
  output logic        rd_layer,
  output logic        swap_ack,
  output logic [7:0]  drop_cnt,
  output swap_state_e state
);

  logic        frame_done_q;
  logic        vblank_q;
  logic        fd_edge;
  logic        vb_edge;
  logic        do_swap;
  logic        do_drop;
  swap_state_e state_q;
  swap_state_e state_d;

  assign fd_edge = frame_done & ~frame_done_q;
  assign vb_edge = vblank & ~vblank_q;
  assign state   = state_q;

  // Previous-cycle copies of the event inputs for rising-edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      frame_done_q <= frame_done;
      vblank_q     <= vblank;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= SHOW;
    else       state_q <= state_d;
  end

  // Next state: a completed frame arms the swap, the next vblank edge performs it.
  // A frame completing on the very vblank edge that swaps keeps the FSM armed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW: if (fd_edge) state_d = PEND;
      PEND: if (vb_edge && !fd_edge) state_d = SHOW;
      default: state_d = SHOW;
    endcase
  end

  // FSM actions: swap on vblank edge while armed, drop when a newer frame overwrites.
  always_comb begin
    do_swap = 1'b0;
    do_drop = 1'b0;
    if (state_q == PEND) begin
      do_swap = vb_edge;
      do_drop = fd_edge & ~vb_edge;
    end
  end

  // Registered layer select, swap pulse and saturating drop counter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_layer <= 1'b0;
      swap_ack <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      rd_layer <= rd_layer ^ do_swap;
      swap_ack <= do_swap;
      if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/chameleon_fb_reader.sv
// Scan-out side of the double-buffered 256x256 RGB332 frame buffer.
// Build macro CHAMELEON_FB_PATTERN_EN adds pattern_sel, which replaces VRAM data
// with an 8x8 colour grid derived from the pixel position.
//
// VRAM read interface: vram_rd is a single-cycle strobe with vram_addr valid in the
// same cycle; the memory returns vram_q in the following cycle. There is no
// back-pressure: every strobe yields exactly one data word one cycle later.
module chameleon_fb_reader
  import chameleon_fb_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [8:0]        hcount,
  input  logic [8:0]        vcount,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              frame_done,
`ifdef CHAMELEON_FB_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [7:0]        vram_q,
  output logic              wr_layer,
  output logic              rd_layer,
  output logic              swap_ack,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              de,
  output swap_state_e       swap_state
);

  logic      p1_valid, p2_valid;
  pix_kind_e p1_kind, p2_kind;
  rgb888_t   pix_q;
  logic      in_range;

`ifdef CHAMELEON_FB_PATTERN_EN
  rgb332_t   p1_pat, p2_pat;
  logic      p1_use_pat, p2_use_pat;
`endif

  chameleon_fb_swap u_swap (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .frame_done (frame_done),
    .vblank     (vblank),
    .rd_layer   (rd_layer),
    .swap_ack   (swap_ack),
    .drop_cnt   (drop_cnt),
    .state      (swap_state)
  );

  assign wr_layer = ~rd_layer;
  assign in_range = (hcount < 9'(H_ACTIVE)) && (vcount < 9'(V_ACTIVE));
  assign r  = pix_q.r;
  assign g  = pix_q.g;
  assign b  = pix_q.b;

  // Stage 0: classify the pixel slot and issue the VRAM read for visible in-range pixels.
  // Address = rd_layer*LAYER_SIZE + row*256 + column, i.e. a plain concatenation.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vram_addr <= '0;
      vram_rd   <= 1'b0;
      p1_valid  <= 1'b0;
      p1_kind   <= PK_BLANK;
    end else begin
      vram_rd  <= 1'b0;
      p1_valid <= ce_pix;
      if (ce_pix) begin
        if (hblank || vblank) begin
          p1_kind <= PK_BLANK;
        end else if (!in_range) begin
          p1_kind <= PK_OOR;
        end else begin
          p1_kind   <= PK_READ;
          vram_addr <= {rd_layer, vcount[7:0], hcount[7:0]};
          vram_rd   <= 1'b1;
        end
      end
    end
  end

`ifdef CHAMELEON_FB_PATTERN_EN
  // Pattern byte and select are captured with the pixel so later timing changes do not matter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      p1_pat     <= '0;
      p1_use_pat <= 1'b0;
      p2_pat     <= '0;
      p2_use_pat <= 1'b0;
    end else begin
      if (ce_pix) begin
        p1_pat     <= {hcount[7:5], vcount[7:5], hcount[4:3]};
        p1_use_pat <= pattern_sel;
      end
      p2_pat     <= p1_pat;
      p2_use_pat <= p1_use_pat;
    end
  end
`endif

  // Delay slot covering the VRAM read latency.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      p2_valid <= 1'b0;
      p2_kind  <= PK_BLANK;
    end else begin
      p2_valid <= p1_valid;
      p2_kind  <= p1_kind;
    end
  end

  // Stage 1: capture returned data, expand to RGB888 and hold until the next pixel.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pix_q <= '0;
      de    <= 1'b0;
    end else if (p2_valid) begin
      case (p2_kind)
        PK_READ: begin
`ifdef CHAMELEON_FB_PATTERN_EN
          pix_q <= rgb332_to_888(p2_use_pat ? p2_pat : vram_q);
`else
          pix_q <= rgb332_to_888(vram_q);
`endif
          de    <= 1'b1;
        end
        PK_OOR: begin
          pix_q <= '0;
          de    <= 1'b1;
        end
        default: begin
          pix_q <= '0;
          de    <= 1'b0;
        end
      endcase
    end
  end

endmodule
